sysarr_ctrl: RTL

//   Feeds and drains the 3x3 systolic array (sysarr) for one C = A*B job. Latches full A and B
//   on a start handshake and drives the diagonally skewed wavefronts onto a00..a40 / b00..b04.

---
 rtl/sysarr_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sysarr_ctrl.sv
// Feed/drain controller for the 3x3 systolic array: skews A and B onto the array edges,
// captures C from the array outputs on a fixed schedule and presents it with a done pulse.
module sysarr_ctrl #(
    parameter int W          = 32,
    parameter int CAP_OFFSET = 5
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [9*W-1:0] a_mat,
    input  logic [9*W-1:0] b_mat,
    output logic           busy,
    output logic           done,
    output logic [9*W-1:0] c_mat,
    output logic [W-1:0]   a00,
    output logic [W-1:0]   a10,
    output logic [W-1:0]   a20,
    output logic [W-1:0]   a30,
    output logic [W-1:0]   a40,
    output logic [W-1:0]   b00,
    output logic [W-1:0]   b01,
    output logic [W-1:0]   b02,
    output logic [W-1:0]   b03,
    output logic [W-1:0]   b04,
    output logic [W-1:0]   c00,
    output logic [W-1:0]   c01,
    output logic [W-1:0]   c02,
    output logic [W-1:0]   c10,
    output logic [W-1:0]   c20,
    input  logic [W-1:0]   c53,
    input  logic [W-1:0]   c54,
    input  logic [W-1:0]   c55,
    input  logic [W-1:0]   c35,
    input  logic [W-1:0]   c45
);

    localparam int KW = $clog2(CAP_OFFSET + 4);

    localparam logic [KW-1:0] K_FEED_LAST = KW'(2);
    localparam logic [KW-1:0] K_WAIT_LAST = KW'(CAP_OFFSET - 1);
    localparam logic [KW-1:0] K_CAP0      = KW'(CAP_OFFSET);
    localparam logic [KW-1:0] K_CAP1      = KW'(CAP_OFFSET + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    // With the minimum capture offset the wait phase vanishes entirely.
    localparam state_t AFTER_FEED = (CAP_OFFSET == 3) ? S_DRAIN : S_WAIT;

    state_t         state;
    logic [KW-1:0]  k;
    logic [9*W-1:0] a_held;
    logic [9*W-1:0] b_held;
    logic [W-1:0]   in_a   [9];
    logic [W-1:0]   in_b   [9];
    logic [W-1:0]   held_a [9];
    logic [W-1:0]   held_b [9];
    logic [W-1:0]   a_wave [5];
    logic [W-1:0]   b_wave [5];
    logic [W-1:0]   next_a [5];
    logic [W-1:0]   next_b [5];
    logic [W-1:0]   shadow [8];
    logic [9*W-1:0] shadow_flat;
    logic           accept;
    logic           feed_on;
    logic [1:0]     feed_row;

    assign accept = start && !busy;

    for (genvar i = 0; i < 9; i++) begin : g_unpack
        assign in_a[i]   = a_mat[i*W +: W];
        assign in_b[i]   = b_mat[i*W +: W];
        assign held_a[i] = a_held[i*W +: W];
        assign held_b[i] = b_held[i*W +: W];
    end

    // C22 arrives in the last drain cycle, so it bypasses the shadow straight into c_mat.
    for (genvar i = 0; i < 8; i++) begin : g_shadow
        assign shadow_flat[i*W +: W] = shadow[i];
    end
    assign shadow_flat[8*W +: W] = c55;

    // Row t of A enters on a(t..t+2)0 and column t of B on b0(t..t+2); the accept edge
    // loads wavefront 0 directly from the inputs since the held copy is not yet valid.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            next_a[i] = '0;
            next_b[i] = '0;
        end
        feed_on  = accept || (state == S_FEED && k != K_FEED_LAST);
        feed_row = accept ? 2'd0 : 2'(k + 1'b1);
        for (int t = 0; t < 3; t++) begin
            for (int p = 0; p < 3; p++) begin
                if (feed_on && feed_row == 2'(t)) begin
                    next_a[3'(t + p)] = accept ? in_a[4'(3*t + p)] : held_a[4'(3*t + p)];
                    next_b[3'(t + p)] = accept ? in_b[4'(3*p + t)] : held_b[4'(3*p + t)];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            c_mat  <= '0;
            a_held <= '0;
            b_held <= '0;
            a_wave <= '{default: '0};
            b_wave <= '{default: '0};
            shadow <= '{default: '0};
        end else begin
            done   <= 1'b0;
            a_wave <= next_a;
            b_wave <= next_b;
            unique case (state)
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        a_held <= a_mat;
                        b_held <= b_mat;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= S_FEED;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FEED: begin
                    k <= k + 1'b1;
                    if (k == K_FEED_LAST) state <= AFTER_FEED;
                end
                S_WAIT: begin
                    k <= k + 1'b1;
                    if (k == K_WAIT_LAST) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    k <= k + 1'b1;
                    if (k == K_CAP0) begin
                        shadow[0] <= c55;
                        shadow[1] <= c45;
                        shadow[2] <= c35;
                        shadow[3] <= c54;
                        shadow[6] <= c53;
                    end else if (k == K_CAP1) begin
                        shadow[4] <= c55;
                        shadow[5] <= c45;
                        shadow[7] <= c54;
                    end else begin
                        c_mat <= shadow_flat;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign a00 = a_wave[0];
    assign a10 = a_wave[1];
    assign a20 = a_wave[2];
    assign a30 = a_wave[3];
    assign a40 = a_wave[4];
    assign b00 = b_wave[0];
    assign b01 = b_wave[1];
    assign b02 = b_wave[2];
    assign b03 = b_wave[3];
    assign b04 = b_wave[4];

    assign c00 = '0;
    assign c01 = '0;
    assign c02 = '0;
    assign c10 = '0;
    assign c20 = '0;

endmodule
